// File: rtl/cpri_rxdata_mc_buffer.sv
// Multi-lane CPRI RX word buffer: per-lane circular buffers feeding one ready/valid
// chunk stream. Chunks are granted round-robin and read with a 2-entry skid on the output.
module cpri_rxdata_mc_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4,
  parameter int DEPTH      = 2048,
  parameter int CHUNK_LEN  = 96,
  parameter int SEQ_W      = 7,
  parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int LVL_W     = AW + 1
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] i_rx_data,
  input  logic [NUM_LANES-1:0]            i_rvalid,
  input  logic                            i_rready,
  input  logic                            i_clr_ovf,
  output logic [DATA_WIDTH-1:0]           o_tx_data,
  output logic [SEQ_W-1:0]                o_tx_addr,
  output logic [LANE_W-1:0]               o_tx_lane,
  output logic                            o_tx_last,
  output logic                            o_tvalid,
  output logic [NUM_LANES-1:0]            o_overflow,
  output logic [NUM_LANES*LVL_W-1:0]      o_level
);

  localparam logic [LVL_W-1:0] ONE       = LVL_W'(1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] CHUNK_LVL = LVL_W'(CHUNK_LEN);
  localparam logic [SEQ_W-1:0] LAST_IDX  = SEQ_W'(CHUNK_LEN - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SEQ_W-1:0]      addr;
    logic [LANE_W-1:0]     lane;
    logic                  last;
  } beat_t;

  state_t                state_q, state_d;
  logic [LVL_W-1:0]      wptr_q [NUM_LANES];
  logic [LVL_W-1:0]      wptr_d [NUM_LANES];
  logic [LVL_W-1:0]      rptr_q [NUM_LANES];
  logic [LVL_W-1:0]      rptr_d [NUM_LANES];
  logic [LVL_W-1:0]      level  [NUM_LANES];
  logic [NUM_LANES-1:0]  wr_en;
  logic [NUM_LANES-1:0]  ovf_q, ovf_d;
  logic [LANE_W-1:0]     rr_q, rr_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [SEQ_W-1:0]      idx_q, idx_d;

  logic                  grant_found;
  logic [LANE_W-1:0]     grant_lane;
  logic [LANE_W-1:0]     cand;
  logic                  issue;
  logic                  can_issue;
  logic [LANE_W-1:0]     rd_lane;
  logic [SEQ_W-1:0]      rd_idx;
  logic [AW-1:0]         rd_addr;

  logic                  rv_q, rv_d;
  logic [LANE_W-1:0]     rv_lane_q, rv_lane_d;
  logic [SEQ_W-1:0]      rv_idx_q, rv_idx_d;
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_LANES][DEPTH];

  logic [1:0]            cnt_q, cnt_d;
  beat_t                 e0_q, e0_d, e1_q, e1_d;
  beat_t                 new_beat;
  logic                  pop;
  logic [2:0]            occ;

  // Write side, overflow flags and fill levels
  always_comb begin
    o_level = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      level[k]  = wptr_q[k] - rptr_q[k];
      wr_en[k]  = i_rvalid[k] && (level[k] != FULL_LVL);
      wptr_d[k] = wr_en[k] ? wptr_q[k] + ONE : wptr_q[k];
      ovf_d[k]  = (ovf_q[k] && !i_clr_ovf) || (i_rvalid[k] && !wr_en[k]);
      o_level[k*LVL_W +: LVL_W] = level[k];
    end
  end

  // Reads are issued only when the skid can take every word already in flight
  assign pop       = o_tvalid && i_rready;
  assign occ       = {1'b0, cnt_q} + {2'b00, rv_q};
  assign can_issue = i_rready && ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    issue       = 1'b0;
    rd_lane     = lane_q;
    rd_idx      = idx_q;
    grant_found = 1'b0;
    grant_lane  = rr_q;
    cand        = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = LANE_W'((int'(rr_q) + i) % NUM_LANES);
      if (!grant_found && (level[cand] >= CHUNK_LVL)) begin
        grant_found = 1'b1;
        grant_lane  = cand;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (grant_found && can_issue) begin
          issue   = 1'b1;
          rd_lane = grant_lane;
          rd_idx  = '0;
          lane_d  = grant_lane;
          idx_d   = SEQ_W'(1);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (can_issue) begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
            rr_d    = (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + LANE_W'(1);
          end else begin
            idx_d = idx_q + SEQ_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int k = 0; k < NUM_LANES; k++) begin
      rptr_d[k] = (issue && (rd_lane == LANE_W'(k))) ? rptr_q[k] + ONE : rptr_q[k];
    end
    rd_addr   = rptr_q[rd_lane][AW-1:0];
    rv_d      = issue;
    rv_lane_d = rd_lane;
    rv_idx_d  = rd_idx;
  end

  // Two-entry skid; e0 is the presented output word
  always_comb begin
    new_beat.data = ram_rdata_q;
    new_beat.addr = rv_idx_q;
    new_beat.lane = rv_lane_q;
    new_beat.last = (rv_idx_q == LAST_IDX);
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({rv_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = new_beat;
        else               e1_d = new_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = new_beat;
        end else begin
          e0_d = e1_q;
          e1_d = new_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wr_en[k]) mem_q[k][wptr_q[k][AW-1:0]] <= i_rx_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    if (issue) ram_rdata_q <= mem_q[rd_lane][rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      for (int k = 0; k < NUM_LANES; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
      end
      ovf_q     <= '0;
      rr_q      <= '0;
      lane_q    <= '0;
      idx_q     <= '0;
      rv_q      <= 1'b0;
      rv_lane_q <= '0;
      rv_idx_q  <= '0;
      cnt_q     <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
    end else begin
      state_q   <= state_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
      end
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      lane_q    <= lane_d;
      idx_q     <= idx_d;
      rv_q      <= rv_d;
      rv_lane_q <= rv_lane_d;
      rv_idx_q  <= rv_idx_d;
      cnt_q     <= cnt_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
    end
  end

  assign o_tvalid   = (cnt_q != 2'd0);
  assign o_tx_data  = e0_q.data;
  assign o_tx_addr  = e0_q.addr;
  assign o_tx_lane  = e0_q.lane;
  assign o_tx_last  = e0_q.last;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_cpri_rxdata_mc_buffer.sv
// Bench for cpri_rxdata_mc_buffer: per-lane word queues plus a round-robin chunk
// planner predict the output stream; a negedge monitor checks every transfer.
module tb_cpri_rxdata_mc_buffer;
  localparam int DW = 64, NL = 4, DEPTH = 2048, CL = 96, SEQ_W = 7, LANE_W = 2, LVL_W = 12;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NL*DW-1:0]  i_rx_data = '0;
  logic [NL-1:0]     i_rvalid = '0;
  logic              i_rready = 1'b0;
  logic              i_clr_ovf = 1'b0;
  logic [DW-1:0]     o_tx_data;
  logic [SEQ_W-1:0]  o_tx_addr;
  logic [LANE_W-1:0] o_tx_lane;
  logic              o_tx_last;
  logic              o_tvalid;
  logic [NL-1:0]     o_overflow;
  logic [NL*LVL_W-1:0] o_level;

  cpri_rxdata_mc_buffer #(.DATA_WIDTH(DW), .NUM_LANES(NL), .DEPTH(DEPTH),
                          .CHUNK_LEN(CL), .SEQ_W(SEQ_W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rvalid(i_rvalid),
    .i_rready(i_rready), .i_clr_ovf(i_clr_ovf), .o_tx_data(o_tx_data),
    .o_tx_addr(o_tx_addr), .o_tx_lane(o_tx_lane), .o_tx_last(o_tx_last),
    .o_tvalid(o_tvalid), .o_overflow(o_overflow), .o_level(o_level));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]     d;
    logic [SEQ_W-1:0]  a;
    logic [LANE_W-1:0] l;
    logic              last;
  } mbeat_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] mq [NL][$];
  mbeat_t exp_q [$];
  bit mov [NL];
  int rr_m = 0;
  logic [DW-1:0] wdata [NL];

  bit mon_en = 0, full_rate = 0, streaming = 0, mid_chunk = 0, prev_stall = 0;
  bit first_arm = 0;
  int gap = 0;
  logic [LANE_W-1:0] first_lane;
  logic [LANE_W-1:0] chunk_lanes [$];
  logic [DW+SEQ_W+LANE_W:0] held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [LVL_W-1:0] lvl(input int k);
    return o_level[k*LVL_W +: LVL_W];
  endfunction

  function automatic logic [NL-1:0] mov_vec();
    logic [NL-1:0] v;
    for (int k = 0; k < NL; k++) v[k] = mov[k];
    return v;
  endfunction

  // Round-robin chunk planner over the model queues (valid when no writes overlap reads)
  task automatic plan();
    bit found;
    found = 1;
    while (found) begin
      found = 0;
      for (int i = 0; i < NL; i++) begin
        int ln;
        ln = (rr_m + i) % NL;
        if (!found && mq[ln].size() >= CL) begin
          for (int w = 0; w < CL; w++) begin
            mbeat_t b;
            b.d = mq[ln].pop_front();
            b.a = SEQ_W'(w);
            b.l = LANE_W'(ln);
            b.last = (w == CL - 1);
            exp_q.push_back(b);
          end
          rr_m = (ln + 1) % NL;
          found = 1;
        end
      end
    end
  endtask

  task automatic wr_cycle(input logic [NL-1:0] mask, input bit clr);
    @(posedge clk); #1;
    i_rvalid = mask;
    i_clr_ovf = clr;
    for (int k = 0; k < NL; k++) begin
      bit drop;
      drop = 0;
      i_rx_data[k*DW +: DW] = wdata[k];
      if (mask[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(wdata[k]);
        else drop = 1;
      end
      if (clr) mov[k] = drop;
      else if (drop) mov[k] = 1;
    end
  endtask

  task automatic wr_idle();
    @(posedge clk); #1;
    i_rvalid = '0;
    i_clr_ovf = 1'b0;
  endtask

  task automatic check_levels(input string nm);
    @(negedge clk);
    for (int k = 0; k < NL; k++) chk(nm, 64'(lvl(k)), 64'(mq[k].size()));
    chk({nm, "_ovf"}, 64'(o_overflow), 64'(mov_vec()));
  endtask

  task automatic drain(input bit rnd, input int budget, input string nm);
    int n;
    n = 0;
    full_rate = !rnd;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      i_rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      n++;
    end
    i_rready = 1'b0;
    full_rate = 0;
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(o_tvalid), 64'd1);
        chk("stall_hold", 64'({o_tx_data, o_tx_addr, o_tx_lane, o_tx_last} != held), 64'd0);
      end
      if (full_rate && streaming && !o_tvalid && exp_q.size() != 0) begin
        gap++;
        chk(mid_chunk ? "bubble_in_chunk" : "bubble_between", 64'(gap > (mid_chunk ? 0 : 1)), 64'd0);
      end
      if (o_tvalid && i_rready) begin
        gap = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(o_tx_addr), 64'hdead);
        end else begin
          mbeat_t b;
          b = exp_q.pop_front();
          chk("beat_data", o_tx_data, b.d);
          chk("beat_addr", 64'(o_tx_addr), 64'(b.a));
          chk("beat_lane", 64'(o_tx_lane), 64'(b.l));
          chk("beat_last", 64'(o_tx_last), 64'(b.last));
        end
        if (o_tx_addr == '0) chunk_lanes.push_back(o_tx_lane);
        if (first_arm) begin
          first_lane = o_tx_lane;
          first_arm = 0;
        end
        mid_chunk = !o_tx_last;
        streaming = (exp_q.size() != 0);
      end
      prev_stall = o_tvalid && !i_rready;
      held = {o_tx_data, o_tx_addr, o_tx_lane, o_tx_last};
    end else begin
      prev_stall = 0;
      streaming = 0;
      gap = 0;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_tvalid"}, 64'(o_tvalid), 64'd0);
    chk({nm, "_data"}, o_tx_data, 64'd0);
    chk({nm, "_tag"}, 64'({o_tx_addr, o_tx_lane, o_tx_last}), 64'd0);
    chk({nm, "_ovf"}, 64'(o_overflow), 64'd0);
    chk({nm, "_level"}, 64'(o_level != '0), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq;
    int cyc;
    bit hit;
    // Reset
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    mon_en = 1;

    // All four lanes preloaded with 192 words each, drained at full rate
    for (int w = 0; w < 2 * CL; w++) begin
      for (int k = 0; k < NL; k++) wdata[k] = {8'(k), 24'h0, 32'(w)};
      wr_cycle(4'hF, 0);
    end
    wr_idle();
    check_levels("preload_lvl");
    chk("preload_lvl_lit", 64'(lvl(2)), 64'd192);
    chunk_lanes.delete();
    plan();
    drain(0, 2000, "four_lane");
    seq = '0;
    foreach (chunk_lanes[i]) if (i < 8) seq[31 - 4*i -: 4] = 4'(chunk_lanes[i]);
    chk("chunk_order_cnt", 64'(chunk_lanes.size()), 64'd8);
    chk("chunk_order", 64'(seq), 64'h01230123);

    // Single lane, ready held high: latency from grant and data 0..95
    i_rready = 1'b1;
    for (int w = 0; w < CL; w++) begin
      wdata[0] = DW'(w);
      wr_cycle(4'h1, 0);
    end
    wr_idle();
    plan();
    full_rate = 1;
    @(negedge clk);
    chk("lat_grant_cycle", 64'(o_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_plus1", 64'(o_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_first_valid", 64'(o_tvalid), 64'd1);
    chk("lat_first_data", o_tx_data, 64'd0);
    chk("lat_first_addr", 64'(o_tx_addr), 64'd0);
    drain(0, 400, "single");

    // Random multi-lane writes then drain with random ready
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NL; k++) wdata[k] = {$urandom, $urandom};
      wr_cycle(4'($urandom_range(0, 15)), 0);
    end
    wr_idle();
    check_levels("rand_lvl");
    plan();
    drain(1, 6000, "rand");
    check_levels("rand_post_lvl");

    // Lane 2 overflow
    for (int w = 0; w < DEPTH + 1; w++) begin
      wdata[2] = {32'h2222_0000, 32'(w)};
      wr_cycle(4'h4, 0);
    end
    wr_idle();
    check_levels("ovf_lvl");
    chk("ovf_lvl_lit", 64'(lvl(2)), 64'd2048);
    chk("ovf_flag_lit", 64'(o_overflow), 64'b0100);
    @(posedge clk); #1 i_clr_ovf = 1'b1;
    for (int k = 0; k < NL; k++) mov[k] = 0;
    @(posedge clk); #1 i_clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    wdata[2] = 64'hbad;
    wr_cycle(4'h4, 1);
    wr_idle();
    @(negedge clk);
    chk("ovf_clr_vs_drop", 64'(o_overflow), 64'b0100);
    chk("ovf_clr_vs_drop_model", 64'(o_overflow), 64'(mov_vec()));
    @(posedge clk); #1 i_clr_ovf = 1'b1;
    for (int k = 0; k < NL; k++) mov[k] = 0;
    @(posedge clk); #1 i_clr_ovf = 1'b0;
    plan();
    drain(1, 12000, "ovf_read");
    check_levels("ovf_post_lvl");

    // Reset in the middle of a chunk
    mon_en = 0;
    for (int w = 0; w < CL; w++) begin
      wdata[0] = {32'h5555_0000, 32'(w)};
      wr_cycle(4'h1, 0);
    end
    wr_idle();
    i_rready = 1'b1;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (o_tvalid && o_tx_addr == SEQ_W'(40)) hit = 1;
    end
    chk("reset_mid_reached", 64'(hit), 64'd1);
    i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    for (int k = 0; k < NL; k++) begin
      mq[k].delete();
      mov[k] = 0;
    end
    exp_q.delete();
    rr_m = 0;
    @(negedge clk);
    check_zero("reset_mid");
    repeat (5) @(negedge clk);
    chk("reset_mid_quiet", 64'(o_tvalid), 64'd0);
    i_rready = 1'b0;
    mon_en = 1;
    for (int w = 0; w < CL; w++) begin
      wdata[0] = {32'h6666_0000, 32'(w)};
      wr_cycle(4'h1, 0);
    end
    wr_idle();
    plan();
    drain(0, 400, "after_reset");

    // Lane 1 holds 95, lane 3 holds 96
    for (int w = 0; w < CL; w++) begin
      wdata[1] = {32'h1111_0000, 32'(w)};
      wdata[3] = {32'h3333_0000, 32'(w)};
      wr_cycle((w < CL - 1) ? 4'b1010 : 4'b1000, 0);
    end
    wr_idle();
    plan();
    first_arm = 1;
    drain(1, 600, "l3_first");
    chk("l3_granted", 64'(first_lane), 64'd3);
    @(negedge clk);
    chk("l1_level_lit", 64'(lvl(1)), 64'd95);
    chk("l1_not_granted", 64'(o_tvalid), 64'd0);
    wdata[1] = {32'h1111_0000, 32'(CL - 1)};
    wr_cycle(4'b0010, 0);
    wr_idle();
    plan();
    first_arm = 1;
    drain(1, 600, "l1_after");
    chk("l1_granted", 64'(first_lane), 64'd1);
    check_levels("final_lvl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpri_rxdata_mc_buffer.md
Name: cpri_rxdata_mc_buffer

Overview:
- Multi-lane successor to the single-lane CPRI RX data FIFO.
- Buffers NUM_LANES independent CPRI RX word streams in per-lane circular buffers.
- Emits whole chunks of CHUNK_LEN words, one lane at a time, on a single ready/valid output stream tagged with lane id, word index and last flag.
- Sits between the CPRI RX deframers and the per-PRB dimension-reduction datapath.

Parameters:
- DATA_WIDTH, 64, width of one data word per lane.
- NUM_LANES, 4, number of input lanes (>=1).
- DEPTH, 2048, words per lane buffer; power of two, >= CHUNK_LEN.
- CHUNK_LEN, 96, words per output chunk (2..2**SEQ_W).
- SEQ_W, 7, width of the word-index output.
- LANE_W, max(1,clog2(NUM_LANES)), width of the lane-id output.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_rx_data  in  NUM_LANES*DATA_WIDTH  lane k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_rvalid  in  NUM_LANES  per-lane write strobe.
- i_rready  in  1  downstream ready.
- i_clr_ovf  in  1  clears all overflow flags.
- o_tx_data  out  DATA_WIDTH  output word.
- o_tx_addr  out  SEQ_W  word index within chunk, 0..CHUNK_LEN-1.
- o_tx_lane  out  LANE_W  source lane of the current chunk.
- o_tx_last  out  1  high on word CHUNK_LEN-1.
- o_tvalid  out  1  output word valid.
- o_overflow  out  NUM_LANES  sticky per-lane overflow.
- o_level  out  NUM_LANES*(clog2(DEPTH)+1)  per-lane fill count.

Behaviour:
- Interface: reset i_reset, synchronous, active-high; clock i_clk.
- Reset clears all pointers, levels, FSM state, round-robin pointer and overflow flags. All outputs are 0 the cycle after reset.
- Reset mid-chunk discards the partial chunk and all buffered data; no further o_tvalid until a new full chunk is present.
- Write side, per lane: when i_rvalid[k] and level[k]<DEPTH, the word is stored at wptr[k] and wptr[k] increments modulo DEPTH.
- Write to a full lane: word dropped, o_overflow[k] set.
- Pointers carry an extra wrap bit.
- level[k] = wptr-rptr (wrap-aware). A same-cycle write and read on one lane leaves level unchanged.
- Overflow flags are sticky and cleared by i_clr_ovf. A new overflow in the same cycle as i_clr_ovf wins (flag stays set).
- Read FSM states:
  - IDLE: each cycle, search lanes starting at rr_ptr. The first lane with level>=CHUNK_LEN is granted; latch o_tx_lane and go to BURST. If no lane qualifies, stay in IDLE.
  - BURST: read CHUNK_LEN consecutive words of the granted lane. The read pointer advances only when the output pipeline can accept a word.
  - On acceptance of the word with o_tx_last: set rr_ptr = granted lane+1 (mod NUM_LANES) and go to IDLE.
- Granting requires only that a full chunk is buffered at grant time, so a chunk is never underrun mid-burst.
- Output is ready/valid. A word transfers when o_tvalid && i_rready.
- While o_tvalid && !i_rready, o_tx_data/addr/lane/last are held stable.
- Buffer memory has 1-cycle read latency, plus a registered output.
- Latency: word 0 reaches o_tvalid 2 cycles after the grant cycle with i_rready high.
- Throughput: one word per cycle while i_rready stays high, including chunk-to-chunk across lanes. At most 1 bubble is allowed between chunks; no bubbles are allowed inside a chunk.
- Skid: a 2-entry skid stage absorbs the RAM latency so that no word is lost or duplicated when i_rready toggles.
- o_tx_addr counts 0..CHUNK_LEN-1 and restarts at 0 for each chunk.
- o_tx_last = (o_tx_addr==CHUNK_LEN-1).
- Width rule: o_level saturates by construction at DEPTH, since writes are blocked when full.

Test Plan:
- Single lane: write 96 words 0..95 on lane 0, i_rready=1 -> 96 contiguous beats: data 0..95, addr 0..95, lane 0, last only at addr 95; first beat 2 cycles after grant.
- All 4 lanes preloaded with 192 words each -> chunk lane order 0,1,2,3,0,1,2,3. Each chunk carries that lane's next 96 words in order; inter-chunk gap <=1 cycle.
- i_rready toggled pseudo-randomly during bursts -> output word sequence identical to the i_rready=1 case; no loss or duplication; outputs stable while stalled.
- Lane 2 written 2049 times with no reads (DEPTH=2048) -> o_overflow[2]=1 and o_level lane 2=2048. Readback yields the first 2048 words. i_clr_ovf clears the flag; i_clr_ovf coincident with a new drop leaves it set.
- Reset asserted at addr 40 of a chunk -> next cycle o_tvalid=0, all levels 0. After 96 fresh writes, the chunk restarts at addr 0 with the new data.
- Lane 1 holds 95 words, lane 3 holds 96 -> lane 3 granted; lane 1 granted only after its 96th write.
